// File: rtl/io_port_ctrl.sv
// ---------------------------------------------------------------------------
// io_port_ctrl
//   Request sequencer for one GPIO port. Converts single CPU I/O requests
//   (valid/ready in, one-cycle response pulse out) into the I/O subsystem
//   strobes: direction write, data write and timed port read. A shadow copy
//   of the direction bit keeps the port-read enable low while the pin drives.
//
// Ports
//   i_clk             clock, rising edge
//   i_rst             asynchronous reset, active high
//   i_req_valid       request present
//   o_req_ready       controller idle, request can be accepted
//   i_req_wr          1 = write, 0 = read
//   i_req_addr        0 = port data, 1 = direction register
//   i_req_wdata       write data (direction writes use bit 0)
//   o_rsp_valid       one-cycle completion pulse
//   o_rsp_rdata       read result, valid with o_rsp_valid, held until next load
//   o_data_0          direction bit to the subsystem (1 = output)
//   o_pdr_en          direction-register write strobe
//   o_data            data-register write value
//   o_port_en         data-register write strobe
//   o_port_rd         port read enable
//   i_port_read_data  pin data returned by the subsystem
//
// States
//   S_IDLE    | waiting for a request, o_req_ready = 1
//   S_WR_DIR  | direction write strobe cycle
//   S_WR_DATA | data write strobe cycle
//   S_RD_PORT | port read enable held while settle counter runs down
//   S_RESP    | response pulse cycle
// ---------------------------------------------------------------------------
module io_port_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_wr,
  input  logic                  i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_data_0,
  output logic                  o_pdr_en,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_port_en,
  output logic                  o_port_rd,
  input  logic [DATA_WIDTH-1:0] i_port_read_data
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_DIR  = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_PORT = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_pdr_en;
  logic                  r_port_en;
  logic                  r_port_rd;
  // Direction shadow; it is also the value presented on o_data_0, since the
  // direction output only ever changes together with the shadow.
  logic                  r_shadow_dir;
  // Data shadow; doubles as the o_data register value.
  logic [DATA_WIDTH-1:0] r_shadow_data;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_accept;
  logic                  w_cnt_zero;
  logic                  w_load_dir;
  logic                  w_load_data;
  logic                  w_rsp_valid_nxt;
  logic                  w_pdr_en_nxt;
  logic                  w_port_en_nxt;
  logic                  w_port_rd_nxt;
  logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;

  assign w_accept   = i_req_valid && (r_state == S_IDLE);
  assign w_cnt_zero = (r_cnt == '0);

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (i_req_wr) begin
            w_next_state = i_req_addr ? S_WR_DIR : S_WR_DATA;
          end else if (i_req_addr || r_shadow_dir) begin
            // Local reads: direction register, or data shadow while driving
            w_next_state = S_RESP;
          end else begin
            w_next_state = S_RD_PORT;
          end
        end
      end
      S_WR_DIR:  w_next_state = S_RESP;
      S_WR_DATA: w_next_state = S_RESP;
      S_RD_PORT: if (w_cnt_zero) w_next_state = S_RESP;
      S_RESP:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, decoded from the
  // state being entered so every output is a flop.
  always_comb begin
    w_rsp_valid_nxt = (w_next_state == S_RESP);
    w_pdr_en_nxt    = (w_next_state == S_WR_DIR);
    w_port_en_nxt   = (w_next_state == S_WR_DATA);
    w_port_rd_nxt   = (w_next_state == S_RD_PORT);

    w_load_dir  = w_accept && i_req_wr && i_req_addr;
    w_load_data = w_accept && i_req_wr && !i_req_addr;

    w_rsp_rdata_nxt = r_rsp_rdata;
    if (w_accept && !i_req_wr) begin
      if (i_req_addr) begin
        w_rsp_rdata_nxt = {{(DATA_WIDTH-1){1'b0}}, r_shadow_dir};
      end else if (r_shadow_dir) begin
        w_rsp_rdata_nxt = r_shadow_data;
      end
    end else if ((r_state == S_RD_PORT) && w_cnt_zero) begin
      w_rsp_rdata_nxt = i_port_read_data;
    end

    w_cnt_nxt = r_cnt;
    if (w_accept && !i_req_wr && !i_req_addr && !r_shadow_dir) begin
      w_cnt_nxt = CNT_W'(SETTLE_CYCLES - 1);
    end else if ((r_state == S_RD_PORT) && !w_cnt_zero) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  // Output and shadow registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_pdr_en      <= 1'b0;
      r_port_en     <= 1'b0;
      r_port_rd     <= 1'b0;
      r_shadow_dir  <= 1'b0;
      r_shadow_data <= '0;
      r_cnt         <= '0;
    end else begin
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_pdr_en    <= w_pdr_en_nxt;
      r_port_en   <= w_port_en_nxt;
      r_port_rd   <= w_port_rd_nxt;
      r_cnt       <= w_cnt_nxt;
      if (w_load_dir) begin
        r_shadow_dir <= i_req_wdata[0];
      end
      if (w_load_data) begin
        r_shadow_data <= i_req_wdata;
      end
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_data_0    = r_shadow_dir;
  assign o_pdr_en    = r_pdr_en;
  assign o_data      = r_shadow_data;
  assign o_port_en   = r_port_en;
  assign o_port_rd   = r_port_rd;

endmodule

// File: tb/tb_io_port_ctrl.sv
module tb_io_port_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic       req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       data_0;
  logic       pdr_en;
  logic [7:0] data;
  logic       port_en;
  logic       port_rd;
  logic [7:0] port_read_data;

  int n_tests = 0;
  int n_fail  = 0;

  io_port_ctrl #(.DATA_WIDTH(8), .SETTLE_CYCLES(2)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .i_req_wr         (req_wr),
    .i_req_addr       (req_addr),
    .i_req_wdata      (req_wdata),
    .o_rsp_valid      (rsp_valid),
    .o_rsp_rdata      (rsp_rdata),
    .o_data_0         (data_0),
    .o_pdr_en         (pdr_en),
    .o_data           (data),
    .o_port_en        (port_en),
    .o_port_rd        (port_rd),
    .i_port_read_data (port_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one request and follow it to its response. Called just after a
  // rising edge; returns one cycle after the response pulse.
  task automatic do_req(input logic wr, input logic addr, input logic [7:0] wd,
                        output int lat, output int rd, output int np,
                        output int ne, output int nr, output int bad);
    int w;
    lat = -1; rd = 0; np = 0; ne = 0; nr = 0; bad = 0;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!req_ready) begin
      bad++;
      return;
    end
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      np += int'(pdr_en); ne += int'(port_en); nr += int'(port_rd);
      if (int'(pdr_en) + int'(port_en) + int'(port_rd) > 1) bad++;
      if (port_rd && data_0) bad++;
      if (rsp_valid) begin
        lat = k;
        rd  = int'(rsp_rdata);
        break;
      end
      @(posedge clk); #1;
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      if (rsp_valid) bad++;
    end
  endtask

  typedef struct {
    logic       wr;
    logic       addr;
    logic [7:0] wdata;
    logic [7:0] pdata;
    int         lat;
    logic [7:0] rdata;
    int         n_pdr;
    int         n_pen;
    int         n_prd;
    logic [7:0] data;
    logic       data_0;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int lat, rd, np, ne, nr, bad;
    int acc, nrsp, stalls, simul, rd2;
    int idx;
    logic a;

    //          wr    addr  wdata  pdata  lat rdata  pdr pen prd data   d0
    vecs[0]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1, 8'h00, 0, 0, 0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'h01, 8'h00, 2, 8'h00, 1, 0, 0, 8'h00, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 8'hA5, 8'h00, 2, 8'h00, 0, 1, 0, 8'hA5, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 8'h11, 1, 8'hA5, 0, 0, 0, 8'hA5, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1, 8'h01, 0, 0, 0, 8'hA5, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 8'h00, 8'h00, 2, 8'h00, 1, 0, 0, 8'hA5, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'h3C, 3, 8'h3C, 0, 0, 2, 8'hA5, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 8'hFE, 8'h00, 2, 8'h00, 1, 0, 0, 8'hA5, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'h5A, 3, 8'h5A, 0, 0, 2, 8'hA5, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'h0F, 8'h00, 2, 8'h00, 0, 1, 0, 8'h0F, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'h03, 8'h00, 2, 8'h00, 1, 0, 0, 8'h0F, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 8'hC3, 1, 8'h0F, 0, 0, 0, 8'h0F, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 8'h00, 8'h00, 1, 8'h01, 0, 0, 0, 8'h0F, 1'b1};

    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 1'b0;
    req_wdata = 8'h00; port_read_data = 8'h00;

    // Reset values while reset is held
    #3;
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_rdata", int'(rsp_rdata), 0);
    chk("rst_data_0",    int'(data_0),    0);
    chk("rst_pdr_en",    int'(pdr_en),    0);
    chk("rst_data",      int'(data),      0);
    chk("rst_port_en",   int'(port_en),   0);
    chk("rst_port_rd",   int'(port_rd),   0);
    chk("rst_req_ready", int'(req_ready), 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven requests
    for (int i = 0; i < 13; i++) begin
      port_read_data = vecs[i].pdata;
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rd, np, ne, nr, bad);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      if (!vecs[i].wr) chk($sformatf("v%0d_rdata", i), rd, int'(vecs[i].rdata));
      chk($sformatf("v%0d_pdr_cycles", i), np, vecs[i].n_pdr);
      chk($sformatf("v%0d_pen_cycles", i), ne, vecs[i].n_pen);
      chk($sformatf("v%0d_prd_cycles", i), nr, vecs[i].n_prd);
      chk($sformatf("v%0d_protocol", i), bad, 0);
      chk($sformatf("v%0d_data", i), int'(data), int'(vecs[i].data));
      chk($sformatf("v%0d_data_0", i), int'(data_0), int'(vecs[i].data_0));
    end

    // Captured port data is unaffected by later pin changes
    do_req(1'b1, 1'b1, 8'h00, lat, rd, np, ne, nr, bad);
    port_read_data = 8'h3C;
    do_req(1'b0, 1'b0, 8'h00, lat, rd, np, ne, nr, bad);
    chk("hold_latency", lat, 3);
    chk("hold_rdata", rd, 8'h3C);
    port_read_data = 8'hFF;
    @(posedge clk); @(posedge clk); #1;
    chk("hold_after_change", int'(rsp_rdata), 8'h3C);

    // Back-to-back requests with valid held high
    acc = 0; nrsp = 0; stalls = 0; simul = 0; rd2 = -1; idx = 0;
    port_read_data = 8'h99;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 1'b1; req_wdata = 8'h00;
    for (int c = 0; c < 30; c++) begin
      a = req_valid && req_ready;
      @(posedge clk); #1;
      if (a) begin
        acc++;
        idx++;
        if (idx == 1) begin
          req_wr = 1'b0; req_addr = 1'b0; req_wdata = 8'h00;
        end else if (idx == 2) begin
          req_wr = 1'b1; req_addr = 1'b0; req_wdata = 8'h77;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (req_valid && !req_ready) stalls++;
      if (int'(pdr_en) + int'(port_en) + int'(port_rd) > 1) simul++;
      if (rsp_valid) begin
        nrsp++;
        if (nrsp == 2) rd2 = int'(rsp_rdata);
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepted", acc, 3);
    chk("b2b_responses", nrsp, 3);
    chk("b2b_stall_cycles", stalls, 5);
    chk("b2b_simultaneous", simul, 0);
    chk("b2b_port_rdata", rd2, 8'h99);
    chk("b2b_data", int'(data), 8'h77);

    // Reset in the middle of a port read
    port_read_data = 8'h44;
    chk("mid_ready", int'(req_ready), 1);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_port_rd_high", int'(port_rd), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_port_rd_async", int'(port_rd), 0);
    chk("mid_ready_in_rst", int'(req_ready), 1);
    chk("mid_data_rst", int'(data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    nrsp = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) nrsp++;
      @(posedge clk); #1;
    end
    chk("mid_no_response", nrsp, 0);
    do_req(1'b0, 1'b1, 8'h00, lat, rd, np, ne, nr, bad);
    chk("mid_dir_latency", lat, 1);
    chk("mid_dir_readback", rd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
